// File: rtl/fifo_read_ctrl.sv
// Read-side pointer/flag controller for the asynchronous FIFO (read clock domain).
// Optional sticky underflow flag is enabled by defining FIFO_RD_UNDERFLOW_EN.
package fifo_pkg;
  localparam int unsigned ADDR_WIDTH = 4;
endpackage

module fifo_read_ctrl #(
  parameter int unsigned ADDR_WIDTH    = fifo_pkg::ADDR_WIDTH,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wr_gray_ptr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic [ADDR_WIDTH:0]   rd_gray_ptr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic                  underflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wr_sync1_q, wr_sync1_d;
  logic [PW-1:0] wr_sync2_q, wr_sync2_d;
  logic [PW-1:0] rd_bin_q, rd_bin_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic [PW-1:0] rd_level_q, rd_level_d;
  logic          empty_q, empty_d;
  logic          almost_empty_q, almost_empty_d;
  logic          rd_valid_q, rd_valid_d;

  logic [PW-1:0] wr_bin_sync_c;
  logic          rd_fire_c;

  // Gray->binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wr_bin_sync_c = '0;
    for (int i = 0; i < int'(PW); i++) begin
      wr_bin_sync_c[i] = ^(wr_sync2_q >> i);
    end
  end

  always_comb begin
    rd_fire_c      = rd_en & ~empty_q;
    wr_sync1_d     = wr_gray_ptr;
    wr_sync2_d     = wr_sync1_q;
    rd_bin_d       = rd_bin_q + PW'(rd_fire_c);
    rd_gray_d      = rd_bin_d ^ (rd_bin_d >> 1);
    rd_level_d     = wr_bin_sync_c - rd_bin_d;
    empty_d        = (rd_level_d == '0);
    almost_empty_d = (rd_level_d <= PW'(AEMPTY_THRESH));
    rd_valid_d     = rd_fire_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sync1_q     <= '0;
      wr_sync2_q     <= '0;
      rd_bin_q       <= '0;
      rd_gray_q      <= '0;
      rd_level_q     <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      rd_valid_q     <= 1'b0;
    end else begin
      wr_sync1_q     <= wr_sync1_d;
      wr_sync2_q     <= wr_sync2_d;
      rd_bin_q       <= rd_bin_d;
      rd_gray_q      <= rd_gray_d;
      rd_level_q     <= rd_level_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      rd_valid_q     <= rd_valid_d;
    end
  end

`ifdef FIFO_RD_UNDERFLOW_EN
  logic underflow_q, underflow_d;

  // Sticky until reset: any read attempt while empty.
  always_comb begin
    underflow_d = underflow_q | (rd_en & empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) underflow_q <= 1'b0;
    else     underflow_q <= underflow_d;
  end

  assign underflow = underflow_q;
`else
  assign underflow = 1'b0;
`endif

  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign rd_level     = rd_level_q;
  assign rd_gray_ptr  = rd_gray_q;
  assign rd_addr      = rd_bin_q[ADDR_WIDTH-1:0];
  assign rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: directed scenarios plus random traffic
// compared against a count-based reference model.
module tb_fifo_read_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_en;
  logic [4:0] wr_gray_ptr;
  logic       empty, almost_empty, rd_valid, underflow;
  logic [4:0] rd_level, rd_gray_ptr;
  logic [3:0] rd_addr;

  int checks = 0;
  int failures = 0;

  // Reference model: unbounded write/read counts and a two-deep delay of the write count.
  int m_wr;
  int m_s1, m_s2;
  int m_rd;
  int m_level;
  bit m_valid;
  bit m_uf;

  fifo_read_ctrl #(.ADDR_WIDTH(4), .AEMPTY_THRESH(2)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_gray_ptr(wr_gray_ptr),
    .empty(empty), .almost_empty(almost_empty), .rd_level(rd_level),
    .rd_gray_ptr(rd_gray_ptr), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit exp_uf;
`ifdef FIFO_RD_UNDERFLOW_EN
    exp_uf = m_uf;
`else
    exp_uf = 1'b0;
`endif
    check("empty", 32'(empty), 32'(m_level == 0));
    check("almost_empty", 32'(almost_empty), 32'(m_level <= 2));
    check("rd_level", 32'(rd_level), 32'(m_level));
    check("rd_gray_ptr", 32'(rd_gray_ptr), 32'(gray5(m_rd)));
    check("rd_addr", 32'(rd_addr), 32'(m_rd % 16));
    check("rd_valid", 32'(rd_valid), 32'(m_valid));
    check("underflow", 32'(underflow), 32'(exp_uf));
    check("inv_empty_level", 32'(empty), 32'(rd_level == 5'd0));
  endtask

  // One clock: drive inputs at negedge, advance model at posedge, check 1 time unit later.
  task automatic step(input logic r, input logic re, input int wr);
    bit fire;
    @(negedge clk);
    rst = r; rd_en = re; m_wr = wr; wr_gray_ptr = gray5(wr);
    @(posedge clk);
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_rd = 0; m_level = 0; m_valid = 0; m_uf = 0;
    end else begin
      fire = re && (m_level != 0);
      if (re && m_level == 0) m_uf = 1;
      m_rd = m_rd + int'(fire);
      m_level = m_s2 - m_rd;
      m_s2 = m_s1;
      m_s1 = wr;
      m_valid = fire;
    end
    #1 check_model();
  endtask

  task automatic hold(input int wr, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, wr);
  endtask

  task automatic reads(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, m_wr);
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_gray_ptr = '0;
    m_wr = 0; m_s1 = 0; m_s2 = 0; m_rd = 0; m_level = 0; m_valid = 0; m_uf = 0;

    // Reset values
    step(1'b1, 1'b0, 0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    check("rst_level", 32'(rd_level), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_gray", 32'(rd_gray_ptr), 32'd0);

    // Sync latency: write visible two edges after sampling
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1);
    check("sync_e0_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 1);
    check("sync_e1_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 1);
    check("sync_e2_empty", 32'(empty), 32'd0);
    check("sync_e2_level", 32'(rd_level), 32'd1);

    // Read last entry, then a read while empty
    step(1'b0, 1'b1, 1);
    check("last_read_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b1, 1);
    check("uf_valid", 32'(rd_valid), 32'd0);
    check("uf_addr", 32'(rd_addr), 32'd1);
    hold(1, 2);

    // Fill to 16 and drain back-to-back
    step(1'b1, 1'b0, 0);
    hold(16, 3);
    check("full_level", 32'(rd_level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 16);
      check("drain_addr", 32'(rd_addr), 32'((i + 1) % 16));
      check("drain_valid", 32'(rd_valid), 32'd1);
    end
    check("drain_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 16);
    check("drain_valid_drop", 32'(rd_valid), 32'd0);

    // Wrap-around 31 -> 0
    hold(31, 3);
    reads(15);
    check("wrap_gray31", 32'(rd_gray_ptr), 32'h10);
    check("wrap_empty31", 32'(empty), 32'd1);
    hold(32, 3);
    reads(1);
    check("wrap_gray0", 32'(rd_gray_ptr), 32'h00);
    check("wrap_level0", 32'(rd_level), 32'd0);

    // Mid-operation reset with rd_en high
    step(1'b1, 1'b0, 0);
    hold(9, 3);
    reads(9);
    hold(16, 3);
    check("pre_rst_level", 32'(rd_level), 32'd7);
    check("pre_rst_addr", 32'(rd_addr), 32'd9);
    step(1'b1, 1'b1, 0);
    check("mid_rst_level", 32'(rd_level), 32'd0);
    check("mid_rst_addr", 32'(rd_addr), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_valid", 32'(rd_valid), 32'd0);

    // Random traffic: at most one write per cycle, never more than 16 outstanding
    for (int i = 0; i < 1500; i++) begin
      int wr;
      logic re;
      wr = m_wr;
      if ((wr - m_rd) < 16 && ($urandom % 3) != 0) wr = wr + 1;
      re = 1'($urandom % 2);
      if (($urandom % 200) == 0) step(1'b1, re, 0);
      else step(1'b0, re, wr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side pointer and flag controller for the asynchronous FIFO, living entirely in the read clock domain. It synchronizes the Gray-coded write pointer from the write domain through two flops and maintains the binary and Gray read pointers. It drives the memory read address and produces registered `empty`, `almost_empty` and fill-level status. It is the counterpart of the write controller and feeds its Gray read pointer back to that side's synchronizer.

## Interface
- `ADDR_WIDTH`, default `fifo_pkg::ADDR_WIDTH` (4): memory address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- `AEMPTY_THRESH`, default 2: `almost_empty` asserts when the fill level is ≤ this value. Legal range 0..2^ADDR_WIDTH-1.

Ports:
- `clk`  in  1  read-domain clock.
- `rst`  in  1  synchronous, active-high reset.
- `rd_en`  in  1  read request.
- `wr_gray_ptr`  in  ADDR_WIDTH+1  Gray write pointer from the write domain; asynchronous to `clk`.
- `empty`  out  1  FIFO empty, registered.
- `almost_empty`  out  1  fill level ≤ AEMPTY_THRESH, registered.
- `rd_level`  out  ADDR_WIDTH+1  entries available, 0..2^ADDR_WIDTH, registered.
- `rd_gray_ptr`  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain.
- `rd_addr`  out  ADDR_WIDTH  memory read address = `rd_bin_ptr[ADDR_WIDTH-1:0]`.
- `rd_valid`  out  1  one-cycle pulse; memory read data is valid this cycle.
- `underflow`  out  1  sticky underflow flag (see Configuration).

## Operation
- Synchronizer: `wr_sync1` ← `wr_gray_ptr`, then `wr_sync2` ← `wr_sync1`. Only `wr_sync2` is used downstream.
- Gray→binary of `wr_sync2`: `b[N] = g[N]`, and `b[i] = b[i+1] ^ g[i]` for i < N, where N = ADDR_WIDTH. The result is `wr_bin_sync`.
- Read handshake: `rd_fire = rd_en & ~empty`. `rd_en` while `empty` is ignored and the pointers hold.
- Next pointer: `rd_bin_next = rd_bin_ptr + rd_fire`, modulo 2^(N+1). Wrap-around from all-ones to 0 is natural.
- Registers updated each edge:
  - `rd_bin_ptr` ← `rd_bin_next`
  - `rd_gray_ptr` ← `rd_bin_next ^ (rd_bin_next >> 1)`
  - `level_next = (wr_bin_sync - rd_bin_next)` modulo 2^(N+1); `rd_level` ← `level_next`
  - `empty` ← (`level_next == 0`), which is equivalent to Gray(`rd_bin_next`) == `wr_sync2`
  - `almost_empty` ← (`level_next <= AEMPTY_THRESH`)
  - `rd_valid` ← `rd_fire`
- Invariants:
  - `empty == (rd_level == 0)` at all times.
  - `rd_level` never exceeds 2^N.
  - Exactly one bit of `rd_gray_ptr` changes per increment.
- Flags are pessimistic only. `empty` can stay high up to the synchronizer latency after a write, but it never deasserts early.
- Reset state, on the first edge with `rst` = 1:
  - all pointers and synchronizer flops = 0
  - `rd_addr` = 0
  - `empty` = 1, `almost_empty` = 1
  - `rd_level` = 0
  - `rd_valid` = 0, `underflow` = 0
- Reset mid-operation: all state returns to the reset values on that edge, and `rd_en` is ignored while `rst` is high. The write side must be reset in the same window; this is a system requirement.

## Timing
- Read latency: with `rd_fire` at edge E, the memory samples `rd_addr` at E. `rd_valid` is high for the cycle after E, aligned with the synchronous-read data. `rd_addr` advances at E.
- Back-to-back reads are allowed every cycle, with no bubble. Reading the last entry sets `empty` at the same edge E.
- Write visibility: new `wr_gray_ptr` sampled at edge E0 → `wr_sync2` at E1 → `empty`, `rd_level` and `almost_empty` update at E2.
- A simultaneous read and sync update are applied at the same edge. `level_next` uses the current `wr_sync2` together with `rd_bin_next`.

## Configuration
- `FIFO_RD_UNDERFLOW_EN` defined:
  - `underflow` ← 1 on any edge where `rd_en & empty & ~rst`.
  - It holds until `rst`.
- Not defined: `underflow` is tied to 0 and no flop is inferred.
- Pointer behaviour is identical in both builds.

## Test plan
All scenarios use ADDR_WIDTH=4 and AEMPTY_THRESH=2.
- Reset: hold `rst` 1 cycle → `empty`=1, `almost_empty`=1, `rd_level`=0, `rd_addr`=0, `rd_gray_ptr`=5'b00000, `rd_valid`=0.
- Sync latency: drive `wr_gray_ptr` 0→5'b00001 at E0 → `empty` falls and `rd_level`=1 at E2, not before.
- Fill and drain: set `wr_gray_ptr` = Gray(16) = 5'b11000 → `rd_level`=16. Then read every cycle → `rd_addr` 0..15, with `rd_valid` pulses. `almost_empty` rises when `rd_level` becomes 2, and `empty` rises at the 16th read edge.
- Wrap-around: start with read and write pointers at binary 31, then write one more (Gray(0)) → read once. `rd_bin_ptr` goes 31→0, `rd_gray_ptr` goes 5'b10000→5'b00000, and `rd_level` = 0.
- Underflow: `rd_en`=1 while `empty` → pointers unchanged, `rd_valid`=0. `underflow`=1 and sticky with `FIFO_RD_UNDERFLOW_EN`; stays 0 without it.
- Mid-operation reset: `rd_level`=7, `rd_addr`=9, assert `rst` with `rd_en`=1 → all outputs return to their reset values on that edge.
